// File: rtl/mem_arbiter_pkg.sv
//------------------------------------------------------------------------------
// mem_arbiter_pkg : shared widths, arbiter state encoding and master indices
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mem_arbiter_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    function automatic state_t own_state(input logic idx);
        return (idx == M1) ? ST_OWN1 : ST_OWN0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_arb_rr2.sv
//------------------------------------------------------------------------------
// arb_rr2 : two-input round-robin pick; on a tie the master that did not own
//           the bus last wins
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module arb_rr2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       valid,
    output logic       pick
);

    always_comb begin
        valid = |req;
        pick  = M0;
        case (req)
            2'b01:   pick = M0;
            2'b10:   pick = M1;
            2'b11:   pick = ~last_owner;
            default: pick = M0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
//------------------------------------------------------------------------------
// mem_arbiter : two-master arbiter for one shared single-cycle memory with
//               bounded bursts and registered read-data return
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m0_gnt,
    output logic              m1_gnt,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m0_rvalid,
    output logic              m1_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] burst_cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             last_owner;
    logic             last_nxt;
    logic             arb_valid;
    logic             arb_pick;
    logic             own_idx;
    logic             own_req;
    logic             oth_req;
    logic             m0_access;
    logic             m1_access;

    arb_rr2 u_arb (
        .req        ({m1_req, m0_req}),
        .last_owner (last_owner),
        .valid      (arb_valid),
        .pick       (arb_pick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            burst_cnt  <= '0;
            last_owner <= M1;
        end else begin
            state      <= state_nxt;
            burst_cnt  <= cnt_nxt;
            last_owner <= last_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = burst_cnt;
        last_nxt  = last_owner;
        own_idx   = (state == ST_OWN1) ? M1 : M0;
        own_req   = (own_idx == M1) ? m1_req : m0_req;
        oth_req   = (own_idx == M1) ? m0_req : m1_req;
        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (arb_valid) begin
                    state_nxt = own_state(arb_pick);
                    last_nxt  = arb_pick;
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (own_req && (burst_cnt < CNT_LAST)) begin
                    cnt_nxt = burst_cnt + CNT_W'(1);
                end else if (oth_req) begin
                    // Burst limit reached or owner idle: hand over to the waiting master
                    state_nxt = own_state(~own_idx);
                    last_nxt  = ~own_idx;
                    cnt_nxt   = '0;
                end else if (own_req) begin
                    cnt_nxt = '0;
                end else begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign m0_gnt    = (state == ST_OWN0);
    assign m1_gnt    = (state == ST_OWN1);
    assign m0_access = m0_gnt & m0_req;
    assign m1_access = m1_gnt & m1_req;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        case (state)
            ST_OWN0: begin
                mem_addr  = m0_addr;
                mem_wdata = m0_wdata;
                mem_we    = m0_req & m0_we;
            end
            ST_OWN1: begin
                mem_addr  = m1_addr;
                mem_wdata = m1_wdata;
                mem_we    = m1_req & m1_we;
            end
            default: begin
                mem_addr  = '0;
                mem_wdata = '0;
                mem_we    = 1'b0;
            end
        endcase
    end

    // Read data is captured at the end of the access cycle and held until the next read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m0_rdata  <= '0;
            m1_rdata  <= '0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
        end else begin
            m0_rvalid <= m0_access & ~m0_we;
            m1_rvalid <= m1_access & ~m1_we;
            if (m0_access && !m0_we) begin
                m0_rdata <= mem_rdata;
            end
            if (m1_access && !m1_we) begin
                m1_rdata <= mem_rdata;
            end
        end
    end

endmodule

`default_nettype wire
